// File: rtl/ysyx_23060203_csr_pkg.sv
// Shared CSR addresses, access-op encoding, mstatus bit positions and the
// read-modify-write helper used by the CSR file.
package ysyx_23060203_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [31:0] MISA_VALUE = 32'h40000100;

  function automatic logic [31:0] csr_apply_op(csr_op_e op, logic [31:0] old_val,
                                               logic [31:0] operand);
    logic [31:0] res;
    res = old_val;
    case (op)
      CSR_OP_RW: res = operand;
      CSR_OP_RS: res = old_val | operand;
      CSR_OP_RC: res = old_val & ~operand;
      default:   res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ysyx_23060203_csr_counter64.sv
// 64-bit counter with independently writable 32-bit halves; a write to either
// half takes effect next cycle and suppresses that cycle's increment.
module ysyx_23060203_csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wen_lo,
  input  logic        wen_hi,
  input  logic [31:0] wdata,
  output logic [63:0] value
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (wen_lo) begin
      value[31:0] <= wdata;
    end else if (wen_hi) begin
      value[63:32] <= wdata;
    end else if (inc) begin
      value <= value + 64'd1;
    end
  end

endmodule

// File: rtl/ysyx_23060203_csr_file.sv
// Machine-mode CSR file: combinational read/illegal decode, single-cycle
// trap entry / mret / Zicsr write (trap > mret > write), 64-bit counters.
module ysyx_23060203_csr_file
  import ysyx_23060203_csr_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MVENDORID   = 32'h79737978,
  parameter logic [XLEN-1:0] MARCHID     = 32'h015fdeeb,
  parameter logic [XLEN-1:0] MHARTID     = '0,
  parameter int              VECTORED_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_valid,
  input  logic [1:0]      csr_op,
  input  logic            csr_wen,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_valid,
  input  logic            instret_inc,
  output logic [XLEN-1:0] trap_target,
  output logic [XLEN-1:0] mret_target,
  output logic            mie_o
);

  csr_op_e     op;
  logic        mie;
  logic        mpie;
  logic [31:0] mtvec;
  logic [31:0] mscratch;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [31:0] mtval;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  logic [31:0] mstatus_val;
  logic [31:0] rd_val;
  logic        implemented;
  logic        write_req;
  logic        csr_we;
  logic [31:0] new_val;
  logic [31:0] vec_off;

  assign op = csr_op_e'(csr_op);

  always_comb begin
    mstatus_val                               = '0;
    mstatus_val[MSTATUS_MIE]                  = mie;
    mstatus_val[MSTATUS_MPIE]                 = mpie;
    mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  always_comb begin
    implemented = 1'b1;
    rd_val      = '0;
    case (csr_addr)
      CSR_MSTATUS:   rd_val = mstatus_val;
      CSR_MISA:      rd_val = MISA_VALUE;
      CSR_MTVEC:     rd_val = mtvec;
      CSR_MSCRATCH:  rd_val = mscratch;
      CSR_MEPC:      rd_val = mepc;
      CSR_MCAUSE:    rd_val = mcause;
      CSR_MTVAL:     rd_val = mtval;
      CSR_MCYCLE:    rd_val = mcycle[31:0];
      CSR_MCYCLEH:   rd_val = mcycle[63:32];
      CSR_MINSTRET:  rd_val = minstret[31:0];
      CSR_MINSTRETH: rd_val = minstret[63:32];
      CSR_MVENDORID: rd_val = MVENDORID;
      CSR_MARCHID:   rd_val = MARCHID;
      CSR_MIMPID:    rd_val = '0;
      CSR_MHARTID:   rd_val = MHARTID;
      default: begin
        implemented = 1'b0;
        rd_val      = '0;
      end
    endcase
  end

  // Address space 0xC00-0xFFF is read-only: writing there is illegal.
  assign write_req   = csr_wen & (op != CSR_OP_NONE);
  assign csr_illegal = csr_valid & (~implemented | ((csr_addr[11:10] == 2'b11) & write_req));
  assign csr_rdata   = csr_illegal ? '0 : rd_val;

  assign csr_we  = csr_valid & write_req & ~csr_illegal & ~trap_valid & ~mret_valid;
  assign new_val = csr_apply_op(op, rd_val, csr_wdata);

  always_ff @(posedge clk) begin
    if (rst) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
    end else if (trap_valid) begin
      mepc   <= trap_pc & ~32'h3;
      mcause <= trap_cause;
      mtval  <= trap_tval;
      mpie   <= mie;
      mie    <= 1'b0;
    end else if (mret_valid) begin
      mie  <= mpie;
      mpie <= 1'b1;
    end else if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie  <= new_val[MSTATUS_MIE];
          mpie <= new_val[MSTATUS_MPIE];
        end
        CSR_MTVEC:    mtvec    <= {new_val[31:2], 1'b0, (VECTORED_EN != 0) & new_val[0]};
        CSR_MSCRATCH: mscratch <= new_val;
        CSR_MEPC:     mepc     <= new_val & ~32'h3;
        CSR_MCAUSE:   mcause   <= new_val;
        CSR_MTVAL:    mtval    <= new_val;
        default: ;
      endcase
    end
  end

  ysyx_23060203_csr_counter64 u_mcycle (
    .clk    (clk),
    .rst    (rst),
    .inc    (1'b1),
    .wen_lo (csr_we & (csr_addr == CSR_MCYCLE)),
    .wen_hi (csr_we & (csr_addr == CSR_MCYCLEH)),
    .wdata  (new_val),
    .value  (mcycle)
  );

  ysyx_23060203_csr_counter64 u_minstret (
    .clk    (clk),
    .rst    (rst),
    .inc    (instret_inc),
    .wen_lo (csr_we & (csr_addr == CSR_MINSTRET)),
    .wen_hi (csr_we & (csr_addr == CSR_MINSTRETH)),
    .wdata  (new_val),
    .value  (minstret)
  );

  // Shifting the whole cause drops bits 31:30, which is exactly 4*cause[30:0] mod 2^32.
  assign vec_off     = trap_cause << 2;
  assign trap_target = {mtvec[31:2], 2'b00} + ((mtvec[0] & trap_cause[31]) ? vec_off : 32'h0);
  assign mret_target = mepc;
  assign mie_o       = mie;

endmodule

// File: tb/tb_ysyx_23060203_csr_file.sv
// Directed bench for the CSR file with an architectural reference model checked every cycle.
module tb_ysyx_23060203_csr_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_valid;
  logic [1:0]  csr_op;
  logic        csr_wen;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_tval;
  logic        mret_valid;
  logic        instret_inc;
  logic [31:0] trap_target;
  logic [31:0] mret_target;
  logic        mie_o;

  int n_vec = 0;
  int n_bad = 0;

  ysyx_23060203_csr_file #(.VECTORED_EN(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .csr_valid   (csr_valid),
    .csr_op      (csr_op),
    .csr_wen     (csr_wen),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal),
    .trap_valid  (trap_valid),
    .trap_cause  (trap_cause),
    .trap_pc     (trap_pc),
    .trap_tval   (trap_tval),
    .mret_valid  (mret_valid),
    .instret_inc (instret_inc),
    .trap_target (trap_target),
    .mret_target (mret_target),
    .mie_o       (mie_o)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural state of the reference model.
  bit          model_live = 0;
  bit          m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cycle, m_instret;

  function automatic bit m_impl(logic [11:0] a);
    return a inside {12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                     12'hB00, 12'hB02, 12'hB80, 12'hB82,
                     12'hF11, 12'hF12, 12'hF13, 12'hF14};
  endfunction

  function automatic logic [31:0] m_read(logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 + (m_mie ? 32'h8 : 32'h0) + (m_mpie ? 32'h80 : 32'h0);
      12'h301: return 32'h40000100;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      12'hB02: return m_instret[31:0];
      12'hB82: return m_instret[63:32];
      12'hF11: return 32'h79737978;
      12'hF12: return 32'h015fdeeb;
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_illegal();
    return csr_valid && (!m_impl(csr_addr) ||
                         (csr_addr >= 12'hC00 && csr_wen && csr_op != 2'b00));
  endfunction

  function automatic logic [31:0] m_newval();
    logic [31:0] old;
    old = m_read(csr_addr);
    if (csr_op == 2'b01) return csr_wdata;
    if (csr_op == 2'b10) return old | csr_wdata;
    return old & ~csr_wdata;
  endfunction

  function automatic logic [31:0] m_target();
    logic [31:0] t;
    t = m_mtvec & ~32'h3;
    if (m_mtvec[0] && trap_cause[31]) t = t + 32'(4 * {1'b0, trap_cause[30:0]});
    return t;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_live <= 1;
      m_mie <= 0; m_mpie <= 0;
      m_mtvec <= 0; m_mscratch <= 0; m_mepc <= 0; m_mcause <= 0; m_mtval <= 0;
      m_cycle <= 0; m_instret <= 0;
    end else begin
      m_cycle   <= m_cycle + 64'd1;
      m_instret <= m_instret + (instret_inc ? 64'd1 : 64'd0);
      if (trap_valid) begin
        m_mepc <= trap_pc & ~32'h3; m_mcause <= trap_cause; m_mtval <= trap_tval;
        m_mpie <= m_mie; m_mie <= 0;
      end else if (mret_valid) begin
        m_mie <= m_mpie; m_mpie <= 1;
      end else if (csr_valid && csr_wen && csr_op != 2'b00 && !m_illegal()) begin
        case (csr_addr)
          12'h300: begin m_mie <= m_newval()[3]; m_mpie <= m_newval()[7]; end
          12'h305: m_mtvec    <= m_newval() & ~32'h2;
          12'h340: m_mscratch <= m_newval();
          12'h341: m_mepc     <= m_newval() & ~32'h3;
          12'h342: m_mcause   <= m_newval();
          12'h343: m_mtval    <= m_newval();
          12'hB00: m_cycle    <= {m_cycle[63:32], m_newval()};
          12'hB80: m_cycle    <= {m_newval(), m_cycle[31:0]};
          12'hB02: m_instret  <= {m_instret[63:32], m_newval()};
          12'hB82: m_instret  <= {m_newval(), m_instret[31:0]};
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (model_live && !rst) begin
      check("cyc_illegal", {31'b0, csr_illegal}, {31'b0, m_illegal()});
      check("cyc_rdata", csr_rdata, m_illegal() ? 32'h0 : m_read(csr_addr));
      check("cyc_trap_target", trap_target, m_target());
      check("cyc_mret_target", mret_target, m_mepc);
      check("cyc_mie", {31'b0, mie_o}, {31'b0, m_mie});
    end
  end

  task automatic idle();
    csr_valid = 0; csr_op = 0; csr_wen = 0; csr_addr = 0; csr_wdata = 0;
    trap_valid = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0;
    mret_valid = 0; instret_inc = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic acc(logic [1:0] op, logic wen, logic [11:0] addr, logic [31:0] wd);
    step();
    csr_valid = 1; csr_op = op; csr_wen = wen; csr_addr = addr; csr_wdata = wd;
  endtask

  task automatic rd(logic [11:0] addr, logic [31:0] exp, string name);
    acc(2'b00, 1'b0, addr, 32'h0);
    #1;
    check(name, csr_rdata, exp);
  endtask

  task automatic peek(logic [11:0] addr, logic [31:0] exp, string name);
    csr_addr = addr;
    #1;
    check(name, csr_rdata, exp);
  endtask

  task automatic trap(logic [31:0] cause, logic [31:0] pc, logic [31:0] tval);
    step();
    trap_valid = 1; trap_cause = cause; trap_pc = pc; trap_tval = tval;
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    csr_valid = 1;
    peek(12'hB00, 32'h0, "mcycle_first");
    peek(12'h300, 32'h1800, "rst_mstatus");
    peek(12'hF11, 32'h79737978, "mvendorid");
    rd(12'hB00, 32'h1, "mcycle_second");
    check("rst_mie", {31'b0, mie_o}, 32'h0);
    check("rst_mret_target", mret_target, 32'h0);
    check("rst_trap_target", trap_target, 32'h0);
    rd(12'h305, 32'h0, "rst_mtvec");

    acc(2'b01, 1, 12'h305, 32'h80000003);
    rd(12'h305, 32'h80000001, "mtvec_warl");
    trap(32'h80000007, 32'h0, 32'h0);
    #1 check("vec_target", trap_target, 32'h8000001C);
    trap(32'h00000002, 32'h0, 32'h0);
    #1 check("exc_target", trap_target, 32'h80000000);
    trap(32'hFFFFFFFF, 32'h0, 32'h0);
    #1 check("vec_target_wrap", trap_target, 32'h7FFFFFFC);

    acc(2'b10, 1, 12'h300, 32'h8);
    rd(12'h300, 32'h1808, "mstatus_set_mie");
    trap(32'h2, 32'h80000106, 32'hDEAD);
    rd(12'h341, 32'h80000104, "trap_mepc");
    check("trap_mret_target", mret_target, 32'h80000104);
    rd(12'h300, 32'h1880, "trap_mstatus");
    step();
    mret_valid = 1;
    rd(12'h300, 32'h1888, "mret_mstatus");
    check("mret_target", mret_target, 32'h80000104);

    acc(2'b01, 1, 12'h340, 32'h11);
    acc(2'b01, 1, 12'h340, 32'h5);
    trap_valid = 1; trap_cause = 32'h3; trap_pc = 32'h80000200; mret_valid = 1;
    rd(12'h340, 32'h11, "prio_mscratch");
    rd(12'h300, 32'h1880, "prio_mstatus");
    rd(12'h342, 32'h3, "prio_mcause");

    acc(2'b11, 1, 12'h340, 32'h1);
    rd(12'h340, 32'h10, "rc_mscratch");
    acc(2'b01, 1, 12'h341, 32'h123);
    rd(12'h341, 32'h120, "mepc_warl");
    acc(2'b01, 1, 12'h301, 32'h0);
    #1 check("misa_write_legal", {31'b0, csr_illegal}, 32'h0);
    rd(12'h301, 32'h40000100, "misa");

    acc(2'b01, 1, 12'hB80, 32'h0);
    acc(2'b01, 1, 12'hB00, 32'hFFFFFFFF);
    rd(12'hB00, 32'hFFFFFFFF, "mcycle_wr_lo");
    peek(12'hB80, 32'h0, "mcycle_wr_hi");
    rd(12'hB80, 32'h1, "mcycle_carry_hi");
    peek(12'hB00, 32'h0, "mcycle_carry_lo");

    acc(2'b01, 1, 12'hB82, 32'hFFFFFFFF);
    acc(2'b01, 1, 12'hB02, 32'hFFFFFFFE);
    step(); instret_inc = 1;
    step(); instret_inc = 1;
    rd(12'hB02, 32'h0, "minstret_wrap_lo");
    peek(12'hB82, 32'h0, "minstret_wrap_hi");
    acc(2'b01, 1, 12'hB02, 32'h7);
    instret_inc = 1;
    rd(12'hB02, 32'h7, "minstret_wr_suppress");

    acc(2'b01, 1, 12'hF12, 32'h55);
    #1 check("ro_write_illegal", {31'b0, csr_illegal}, 32'h1);
    check("ro_write_rdata", csr_rdata, 32'h0);
    acc(2'b00, 0, 12'h7C0, 32'h0);
    #1 check("unimpl_illegal", {31'b0, csr_illegal}, 32'h1);
    acc(2'b10, 0, 12'hF12, 32'hFF);
    #1 check("ro_rs_x0_legal", {31'b0, csr_illegal}, 32'h0);
    check("ro_rs_x0_rdata", csr_rdata, 32'h015fdeeb);

    step();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
